// File: rtl/tty_printer_iot_pkg.sv
// Shared definitions for the console printer IOT responder (device 04).
// Function-bit positions in IR, transmitter states and default bit timing.
package tty_pkg;

  localparam int FN_SKIP = 0;
  localparam int FN_CLR  = 1;
  localparam int FN_LOAD = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

endpackage

// File: rtl/tty_printer_iot_if.sv
// CPU-side IOT bus for the printer: select, instruction bits and AC in,
// status and serial line out. The CPU drives the master side, the printer is the slave.
interface tty_printer_iot_if;

  logic        IOT604x;
  logic [2:0]  IR;
  logic [11:0] AC;
  logic        SKIP;
  logic        IRQ;
  logic        FLAG;
  logic        BUSY;
  logic        TXD;

  modport master (
    output IOT604x, IR, AC,
    input  SKIP, IRQ, FLAG, BUSY, TXD
  );

  modport slave (
    input  IOT604x, IR, AC,
    output SKIP, IRQ, FLAG, BUSY, TXD
  );

endinterface

// File: rtl/uart_tx_shifter.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first, 1 or 2 stop bits.
// o_done is high during the cycle whose closing edge ends the last stop bit.
module uart_tx_shifter
  import tty_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  txState_t          r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bitIdx;
  logic              r_stopCnt;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic              r_busy;
  logic              w_bitEnd;

  assign w_bitEnd = (r_baud == BAUD_LAST);
  assign o_done   = (r_state == STOP) && w_bitEnd && (r_stopCnt == STOP_LAST);
  assign o_txd    = r_txd;
  assign o_busy   = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bitIdx  <= '0;
      r_stopCnt <= 1'b0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      if (r_state != IDLE) begin
        r_baud <= w_bitEnd ? '0 : r_baud + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_shift <= i_data;
            r_baud  <= '0;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bitEnd) begin
            r_txd    <= r_shift[0];
            r_bitIdx <= '0;
            r_state  <= DATA;
          end
        end
        DATA: begin
          // Bit 0 is already on the line when DATA is entered; shift on each bit end.
          if (w_bitEnd) begin
            if (r_bitIdx == 3'd7) begin
              r_txd     <= 1'b1;
              r_stopCnt <= 1'b0;
              r_state   <= STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_txd    <= r_shift[1];
              r_shift  <= {1'b0, r_shift[7:1]};
            end
          end
        end
        STOP: begin
          if (w_bitEnd) begin
            if (r_stopCnt == STOP_LAST) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_stopCnt <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tty_printer_iot.sv
// IOT responder for printer device 04 (604x): strobe detection, printer flag,
// skip and interrupt request, and load gating into the serial transmitter.
module tty_printer_iot
  import tty_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input logic               CLK,
  input logic               RESET,
  tty_printer_iot_if.slave  bus
);

  logic r_selPrev;
  logic r_flag;
  logic r_skip;
  logic w_stb;
  logic w_load;
  logic w_txd;
  logic w_busy;
  logic w_done;
  logic w_unusedAc;

  assign w_unusedAc = ^bus.AC[11:8];

  // One strobe per IOT regardless of how long the select is held.
  assign w_stb  = bus.IOT604x & ~r_selPrev;
  assign w_load = w_stb & bus.IR[FN_LOAD] & ~w_busy;

  uart_tx_shifter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_shifter (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_start (w_load),
    .i_data  (bus.AC[7:0]),
    .o_txd   (w_txd),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_selPrev <= 1'b0;
      r_flag    <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_selPrev <= bus.IOT604x;
      // Frame completion beats a simultaneous IOT clear.
      if (w_done) begin
        r_flag <= 1'b1;
      end else if (w_stb && bus.IR[FN_CLR]) begin
        r_flag <= 1'b0;
      end else if (w_stb && (bus.IR == 3'b000)) begin
        r_flag <= 1'b1;
      end
      if (!bus.IOT604x) begin
        r_skip <= 1'b0;
      end else if (w_stb) begin
        r_skip <= bus.IR[FN_SKIP] & r_flag;
      end
    end
  end

  assign bus.SKIP = r_skip;
  assign bus.FLAG = r_flag;
  assign bus.IRQ  = r_flag;
  assign bus.BUSY = w_busy;
  assign bus.TXD  = w_txd;

endmodule

// File: tb/tb_tty_printer_iot.sv
// Bench for tty_printer_iot with CLKS_PER_BIT=4, STOP_BITS=1: directed IOTs plus
// a frame scoreboard that checks every TXD cycle of each transmitted character.
module tb_tty_printer_iot;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] data;
    int         startCycle;
    bit         isAbort;
  } frameItem_t;

  logic CLK = 1'b0;
  logic RESET;
  int   cycleCount = 0;
  int   checkCount = 0;
  int   passCount  = 0;
  frameItem_t sbQueue[$];

  tty_printer_iot_if bus();

  tty_printer_iot #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycleCount);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic waitUntil(input int target);
    while (cycleCount < target) tick();
  endtask

  // One IOT: raise select for 'hold' cycles, checking SKIP while held and after release.
  task automatic applyStimulus(input logic [2:0] ir, input logic [11:0] ac, input int hold,
                               input logic expSkip, input bit expLoad, input bit expAbort,
                               output int stbCycle);
    frameItem_t item;
    bus.IR      = ir;
    bus.AC      = ac;
    bus.IOT604x = 1'b1;
    stbCycle    = cycleCount + 1;
    if (expLoad) begin
      item.data       = ac[7:0];
      item.startCycle = stbCycle;
      item.isAbort    = expAbort;
      sbQueue.push_back(item);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("skip_held", bus.SKIP, expSkip);
    end
    bus.IOT604x = 1'b0;
    tick();
    checkOutput("skip_drop", bus.SKIP, 1'b0);
  endtask

  // Frame monitor: pops the expected character when TXD first falls and checks every bit cycle.
  initial begin : monitor
    frameItem_t item;
    logic [9:0] frameBits;
    int         startAt;
    bit         aborted;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b0 && bus.TXD === 1'b0) begin
        startAt = cycleCount;
        if (sbQueue.size() == 0) begin
          checkOutput("frame_unexpected", sbQueue.size(), 1);
          repeat (10 * CPB + 2) @(negedge CLK);
        end else begin
          item = sbQueue.pop_front();
          checkOutput("frame_start", startAt, item.startCycle);
          frameBits = {1'b1, item.data, 1'b0};
          aborted   = 1'b0;
          for (int k = 0; k < 10 * CPB; k++) begin
            if (k > 0) @(negedge CLK);
            if (RESET === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            checkOutput("frame_txd", bus.TXD, frameBits[k / CPB]);
            checkOutput("frame_busy", bus.BUSY, 1'b1);
            if (k == 10 * CPB - 1) checkOutput("flag_early", bus.FLAG, 1'b0);
          end
          checkOutput("frame_abort", aborted, item.isAbort);
          if (!aborted) begin
            @(negedge CLK);
            checkOutput("end_txd", bus.TXD, 1'b1);
            checkOutput("end_busy", bus.BUSY, 1'b0);
            checkOutput("end_flag", bus.FLAG, 1'b1);
            checkOutput("end_irq", bus.IRQ, 1'b1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int stb;
    int stb2;
    RESET       = 1'b1;
    bus.IOT604x = 1'b0;
    bus.IR      = 3'b000;
    bus.AC      = 12'o0000;
    tick();
    tick();
    RESET = 1'b0;
    checkOutput("rst_txd", bus.TXD, 1'b1);
    checkOutput("rst_busy", bus.BUSY, 1'b0);
    checkOutput("rst_flag", bus.FLAG, 1'b0);
    checkOutput("rst_skip", bus.SKIP, 1'b0);
    checkOutput("rst_irq", bus.IRQ, 1'b0);

    // Reset in the middle of a frame aborts it without raising the flag.
    applyStimulus(3'b100, 12'o0176, 1, 1'b0, 1'b1, 1'b1, stb);
    waitUntil(stb + 10);
    checkOutput("pre_rst_busy", bus.BUSY, 1'b1);
    RESET = 1'b1;
    tick();
    checkOutput("abort_txd", bus.TXD, 1'b1);
    tick();
    RESET = 1'b0;
    checkOutput("abort_busy", bus.BUSY, 1'b0);
    checkOutput("abort_flag", bus.FLAG, 1'b0);
    checkOutput("abort_skip", bus.SKIP, 1'b0);
    waitUntil(stb + 50);
    checkOutput("abort_noflag", bus.FLAG, 1'b0);

    // 6046 'A' with the select held 5 cycles: exactly one frame.
    applyStimulus(3'b110, 12'o0101, 5, 1'b0, 1'b1, 1'b0, stb);
    waitUntil(stb + 41);
    checkOutput("flag_done", bus.FLAG, 1'b1);
    checkOutput("irq_done", bus.IRQ, 1'b1);

    // Skip behaviour with the flag set and clear.
    applyStimulus(3'b001, 12'o0000, 4, 1'b1, 1'b0, 1'b0, stb);
    checkOutput("flag_after_6041", bus.FLAG, 1'b1);
    applyStimulus(3'b010, 12'o0000, 2, 1'b0, 1'b0, 1'b0, stb);
    checkOutput("flag_after_6042", bus.FLAG, 1'b0);
    applyStimulus(3'b001, 12'o0000, 4, 1'b0, 1'b0, 1'b0, stb);
    applyStimulus(3'b000, 12'o0000, 2, 1'b0, 1'b0, 1'b0, stb);
    checkOutput("flag_after_6040", bus.FLAG, 1'b1);
    applyStimulus(3'b011, 12'o0000, 3, 1'b1, 1'b0, 1'b0, stb);
    checkOutput("flag_after_6043", bus.FLAG, 1'b0);
    checkOutput("irq_after_6043", bus.IRQ, 1'b0);

    // Second load 12 cycles into a frame is dropped.
    applyStimulus(3'b110, 12'o0123, 1, 1'b0, 1'b1, 1'b0, stb);
    waitUntil(stb + 11);
    applyStimulus(3'b110, 12'o0132, 2, 1'b0, 1'b0, 1'b0, stb2);
    checkOutput("busy_mid", bus.BUSY, 1'b1);
    checkOutput("flag_mid", bus.FLAG, 1'b0);
    waitUntil(stb + 41);
    checkOutput("flag_first_end", bus.FLAG, 1'b1);
    waitUntil(stb + 60);
    checkOutput("busy_no_second", bus.BUSY, 1'b0);
    checkOutput("txd_no_second", bus.TXD, 1'b1);

    // Flag clear landing on the completion edge loses to completion.
    applyStimulus(3'b110, 12'o0125, 1, 1'b0, 1'b1, 1'b0, stb);
    waitUntil(stb + 39);
    applyStimulus(3'b010, 12'o0000, 1, 1'b0, 1'b0, 1'b0, stb2);
    checkOutput("flag_cmpl_wins", bus.FLAG, 1'b1);
    applyStimulus(3'b010, 12'o0000, 1, 1'b0, 1'b0, 1'b0, stb);
    checkOutput("flag_cleared", bus.FLAG, 1'b0);
    applyStimulus(3'b000, 12'o0000, 1, 1'b0, 1'b0, 1'b0, stb);
    checkOutput("flag_set_again", bus.FLAG, 1'b1);
    checkOutput("irq_set_again", bus.IRQ, 1'b1);

    waitUntil(cycleCount + 10);
    checkOutput("sb_drain", sbQueue.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
